// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = x - y - borrow_in, STEP bits per clock, LSB slice first.
// Optional signed-overflow flag output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             borrow,
  output logic             ovf
`else
  output logic             borrow
`endif
);

  localparam int N  = (STEP > 0) ? WIDTH / STEP : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_cfg
      $error("serial_subtractor: WIDTH must be >= 1 and an integer multiple of STEP");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic             br;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             x_msb;
  logic             y_msb;
`endif

  // Ripple the borrow through one STEP-bit slice; returns {borrow_out, diff_bits}.
  function automatic logic [STEP:0] sub_slice(input logic [STEP-1:0] a,
                                              input logic [STEP-1:0] b,
                                              input logic            bi);
    logic [STEP-1:0] d;
    logic            bw;
    bw = bi;
    for (int i = 0; i < STEP; i++) begin
      d[i] = a[i] ^ b[i] ^ bw;
      bw   = (~a[i] & (b[i] ^ bw)) | (b[i] & bw);
    end
    return {bw, d};
  endfunction

  logic [STEP:0]         slice;
  logic [WIDTH+STEP-1:0] cat;
  logic [WIDTH-1:0]      res_next;

  // New slice bits enter from the MSB side; after N slices the LSB slice sits at bit 0.
  always_comb begin
    slice    = sub_slice(xr[STEP-1:0], yr[STEP-1:0], br);
    cat      = {slice[STEP-1:0], res};
    res_next = cat[WIDTH+STEP-1:STEP];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      br     <= 1'b0;
      res    <= '0;
      cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf    <= 1'b0;
      x_msb  <= 1'b0;
      y_msb  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            xr    <= x;
            yr    <= y;
            br    <= borrow_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            x_msb <= x[WIDTH-1];
            y_msb <= y[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          xr  <= xr >> STEP;
          yr  <= yr >> STEP;
          br  <= slice[STEP];
          res <= res_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            diff   <= res_next;
            borrow <= slice[STEP];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf    <= (x_msb != y_msb) && (res_next[WIDTH-1] != x_msb);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 with STEP=1, 4 and 8 instances side by side.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  st;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        bin;
  logic [2:0]  busy_w;
  logic [2:0]  done_w;
  logic [2:0]  borrow_w;
  logic [23:0] diff_w;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic [2:0]  ovf_w;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .start(st[0]), .x(x), .y(y), .borrow_in(bin),
    .busy(busy_w[0]), .done(done_w[0]), .diff(diff_w[7:0]),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf_w[0]),
`endif
    .borrow(borrow_w[0]));

  serial_subtractor #(.WIDTH(8), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .start(st[1]), .x(x), .y(y), .borrow_in(bin),
    .busy(busy_w[1]), .done(done_w[1]), .diff(diff_w[15:8]),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf_w[1]),
`endif
    .borrow(borrow_w[1]));

  serial_subtractor #(.WIDTH(8), .STEP(8)) u_s8 (
    .clk(clk), .rst(rst), .start(st[2]), .x(x), .y(y), .borrow_in(bin),
    .busy(busy_w[2]), .done(done_w[2]), .diff(diff_w[23:16]),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf_w[2]),
`endif
    .borrow(borrow_w[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: 9-bit unsigned subtraction, bit 8 is the borrow out.
  function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {8'd0, bi};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on instance k; inputs are scrambled after capture to show they are ignored.
  task automatic op(input int k, input logic [7:0] a, input logic [7:0] b, input logic bi,
                    input logic [7:0] ed, input logic eb, input string tag);
    int         n;
    int         bc;
    int         di;
    int         both;
    logic [7:0] gd;
    logic       gb;
    n    = (k == 0) ? 8 : (k == 1) ? 2 : 1;
    bc   = 0;
    di   = -1;
    both = 0;
    gd   = 8'h00;
    gb   = 1'b0;
    x = a; y = b; bin = bi; st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
    for (int j = 0; j < n + 4; j++) begin
      if (busy_w[k]) bc++;
      if (busy_w[k] && done_w[k]) both = 1;
      if (done_w[k] && di < 0) begin
        di = j;
        gd = diff_w[8*k +: 8];
        gb = borrow_w[k];
      end
      x = 8'($urandom); y = 8'($urandom); bin = 1'($urandom);
      tick();
    end
    chk({tag, " busy_cycles"}, bc, n);
    chk({tag, " done_at"}, di, n);
    chk({tag, " diff"}, gd, ed);
    chk({tag, " borrow"}, gb, eb);
    chk({tag, " busy_and_done"}, both, 0);
  endtask

  logic [7:0] bx [5];
  logic [7:0] by [5];
  logic       bb [5];

  initial begin
    int         idx;
    int         cyc;
    int         last;
    int         both;
    int         ndone;
    logic [8:0] r;

    rst = 1'b1; st = 3'b000; x = 8'h00; y = 8'h00; bin = 1'b0;
    tick();
    tick();
    chk("reset busy", busy_w, 3'b000);
    chk("reset done", done_w, 3'b000);
    chk("reset diff", diff_w, 24'h0);
    chk("reset borrow", borrow_w, 3'b000);
    rst = 1'b0;
    tick();

    op(0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "s1 5A-3C");
    op(0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "s1 00-01");
    op(0, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "s1 10-0F-1");
    op(0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "s1 00-00-1");
    op(1, 8'hA3, 8'h5C, 1'b0, 8'h47, 1'b0, "s4 A3-5C");
    op(2, 8'hA3, 8'h5C, 1'b0, 8'h47, 1'b0, "s8 A3-5C");
    op(2, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "s8 00-00-1");
    op(1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "s4 10-0F-1");

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    op(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "s1 80-01");
    chk("ovf 80-01", ovf_w[0], 1'b1);
    op(0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "s1 05-03");
    chk("ovf 05-03", ovf_w[0], 1'b0);
`endif

    // Back-to-back: start held high, next operands presented only in the DONE cycle.
    bx[0] = 8'h12; by[0] = 8'h34; bb[0] = 1'b0;
    bx[1] = 8'hC8; by[1] = 8'h37; bb[1] = 1'b1;
    bx[2] = 8'h7F; by[2] = 8'h80; bb[2] = 1'b0;
    bx[3] = 8'h00; by[3] = 8'h00; bb[3] = 1'b0;
    bx[4] = 8'h00; by[4] = 8'h00; bb[4] = 1'b0;
    x = bx[0]; y = by[0]; bin = bb[0]; st[0] = 1'b1;
    tick();
    idx = 0; cyc = 0; last = -1; both = 0;
    while (idx < 3 && cyc < 60) begin
      if (busy_w[0] && done_w[0]) both = 1;
      if (done_w[0]) begin
        r = ref_sub(bx[idx], by[idx], bb[idx]);
        chk($sformatf("b2b%0d diff", idx), diff_w[7:0], r[7:0]);
        chk($sformatf("b2b%0d borrow", idx), borrow_w[0], r[8]);
        chk($sformatf("b2b%0d done_gap", idx), cyc - last, (idx == 0) ? 9 : 9);
        last = cyc;
        idx++;
        x = bx[idx]; y = by[idx]; bin = bb[idx];
      end else begin
        x = 8'($urandom); y = 8'($urandom); bin = 1'($urandom);
      end
      tick();
      cyc++;
    end
    st[0] = 1'b0;
    chk("b2b results", idx, 3);
    chk("b2b busy_and_done", both, 0);
    tick();
    tick();

    // Reset during the third RUN cycle: everything clears at once, no done afterwards.
    x = 8'h9C; y = 8'h21; bin = 1'b0; st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    tick();
    tick();
    chk("mid busy before rst", busy_w[0], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst busy", busy_w, 3'b000);
    chk("mid rst done", done_w, 3'b000);
    chk("mid rst diff", diff_w, 24'h0);
    chk("mid rst borrow", borrow_w, 3'b000);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      if (done_w != 3'b000) ndone++;
      tick();
    end
    chk("mid rst no done", ndone, 0);
    op(0, 8'h9C, 8'h21, 1'b0, 8'h7B, 1'b0, "s1 after rst 9C-21");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
